// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use, branch redirect, memory stall, MDU busy.
// Optional MDU busy tracking and HI/LO interlock enabled by PIPE_CTRL_MDU_STALL_EN.
module pipe_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_hilo_use,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             ex_mdu_start,
    input  logic             ex_mdu_div,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             pc_sel,
    output logic [1:0]       ifid_sig,
    output logic [1:0]       idex_sig,
    output logic [1:0]       exmem_sig,
    output logic [1:0]       memwb_sig,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int BUSY_W = 16;
    localparam logic [BUSY_W-1:0] MULT_LD = BUSY_W'(MULT_CYCLES);
    localparam logic [BUSY_W-1:0] DIV_LD  = BUSY_W'(DIV_CYCLES);

    localparam logic [1:0] SIG_FLUSH = 2'b00;
    localparam logic [1:0] SIG_LOAD  = 2'b01;
    localparam logic [1:0] SIG_HOLD  = 2'b10;

    logic             load_use;
    logic             hilo_stall;
    logic             sel_rst;
    logic             sel_mem;
    logic             sel_redir;
    logic             sel_haz;
    logic             sel_run;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;

    assign load_use = ex_memread & (ex_rt != 5'd0) &
                      ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

`ifdef PIPE_CTRL_MDU_STALL_EN
    logic [BUSY_W-1:0] busy_d;
    logic [BUSY_W-1:0] busy_q;

    // A new start reloads even if the unit is still busy.
    always_comb begin
        busy_d = busy_q;
        if (ex_mdu_start && mem_ready) begin
            busy_d = ex_mdu_div ? DIV_LD : MULT_LD;
        end else if (busy_q != '0) begin
            busy_d = busy_q - BUSY_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign mdu_busy   = (busy_q != '0);
    assign hilo_stall = id_hilo_use & mdu_busy;
`else
    logic unused_mdu;

    assign unused_mdu = ^{ex_mdu_start, ex_mdu_div, id_hilo_use,
                          MULT_LD, DIV_LD};
    assign mdu_busy   = 1'b0;
    assign hilo_stall = 1'b0;
`endif

    // Mutually exclusive selects so the decoder below is truly one-hot.
    assign sel_rst   = ~rst_n;
    assign sel_mem   = rst_n & ~mem_ready;
    assign sel_redir = rst_n & mem_ready & ex_branch_taken;
    assign sel_haz   = rst_n & mem_ready & ~ex_branch_taken &
                       (load_use | hilo_stall);
    assign sel_run   = rst_n & mem_ready & ~ex_branch_taken &
                       ~(load_use | hilo_stall);

    always_comb begin
        pc_en     = 1'b0;
        pc_sel    = 1'b0;
        ifid_sig  = SIG_FLUSH;
        idex_sig  = SIG_FLUSH;
        exmem_sig = SIG_FLUSH;
        memwb_sig = SIG_FLUSH;
        unique case (1'b1)
            sel_rst: begin
                pc_en = 1'b0;
            end
            sel_mem: begin
                ifid_sig  = SIG_HOLD;
                idex_sig  = SIG_HOLD;
                exmem_sig = SIG_HOLD;
                memwb_sig = SIG_HOLD;
            end
            sel_redir: begin
                pc_en     = 1'b1;
                pc_sel    = 1'b1;
                exmem_sig = SIG_LOAD;
                memwb_sig = SIG_LOAD;
            end
            sel_haz: begin
                ifid_sig  = SIG_HOLD;
                exmem_sig = SIG_LOAD;
                memwb_sig = SIG_LOAD;
            end
            sel_run: begin
                pc_en     = 1'b1;
                ifid_sig  = SIG_LOAD;
                idex_sig  = SIG_LOAD;
                exmem_sig = SIG_LOAD;
                memwb_sig = SIG_LOAD;
            end
            default: begin
                pc_en = 1'b0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (narrow stall counter to reach saturation).
// Expectations follow PIPE_CTRL_MDU_STALL_EN when the build defines it.
module tb_pipe_ctrl;

    localparam int CW = 4;

    localparam logic [7:0] RUN   = 8'b01_01_01_01;
    localparam logic [7:0] HAZ   = 8'b10_00_01_01;
    localparam logic [7:0] REDIR = 8'b00_00_01_01;
    localparam logic [7:0] HOLD  = 8'b10_10_10_10;
    localparam logic [7:0] RST   = 8'b00_00_00_00;

`ifdef PIPE_CTRL_MDU_STALL_EN
    localparam logic MDU = 1'b1;
`else
    localparam logic MDU = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [4:0]    id_rs;
    logic [4:0]    id_rt;
    logic          id_uses_rt;
    logic          id_hilo_use;
    logic          ex_memread;
    logic [4:0]    ex_rt;
    logic          ex_branch_taken;
    logic          ex_mdu_start;
    logic          ex_mdu_div;
    logic          mem_ready;
    logic          pc_en;
    logic          pc_sel;
    logic [1:0]    ifid_sig;
    logic [1:0]    idex_sig;
    logic [1:0]    exmem_sig;
    logic [1:0]    memwb_sig;
    logic          mdu_busy;
    logic [CW-1:0] stall_cnt;

    int n_chk;
    int n_pass;
    logic [CW-1:0] exp_cnt;

    pipe_ctrl #(
        .MULT_CYCLES(4),
        .DIV_CYCLES (32),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .id_hilo_use    (id_hilo_use),
        .ex_memread     (ex_memread),
        .ex_rt          (ex_rt),
        .ex_branch_taken(ex_branch_taken),
        .ex_mdu_start   (ex_mdu_start),
        .ex_mdu_div     (ex_mdu_div),
        .mem_ready      (mem_ready),
        .pc_en          (pc_en),
        .pc_sel         (pc_sel),
        .ifid_sig       (ifid_sig),
        .idex_sig       (idex_sig),
        .exmem_sig      (exmem_sig),
        .memwb_sig      (memwb_sig),
        .mdu_busy       (mdu_busy),
        .stall_cnt      (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_all(input string tag, input logic e_pc_en,
                             input logic e_pc_sel, input logic [7:0] e_sigs,
                             input logic e_busy);
        check({tag, ".pc_en"}, 32'(pc_en), 32'(e_pc_en));
        check({tag, ".pc_sel"}, 32'(pc_sel), 32'(e_pc_sel));
        check({tag, ".sigs"}, 32'({ifid_sig, idex_sig, exmem_sig, memwb_sig}),
              32'(e_sigs));
        check({tag, ".busy"}, 32'(mdu_busy), 32'(e_busy));
        check({tag, ".cnt"}, 32'(stall_cnt), 32'(exp_cnt));
    endtask

    // One cycle: inputs already applied; check on falling edge, then advance.
    task automatic vec(input string tag, input logic e_pc_en,
                       input logic e_pc_sel, input logic [7:0] e_sigs,
                       input logic e_busy);
        @(negedge clk);
        check_all(tag, e_pc_en, e_pc_sel, e_sigs, e_busy);
        @(posedge clk);
        if (!e_pc_en && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_hilo_use = 1'b0;
        ex_memread = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0;
        ex_mdu_start = 1'b0; ex_mdu_div = 1'b0; mem_ready = 1'b1;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        exp_cnt = '0;
        rst_n = 1'b0;
        idle();
        #1;
        check_all("reset", 1'b0, 1'b0, RST, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        vec("idle", 1'b1, 1'b0, RUN, 1'b0);

        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        vec("lu_rs", 1'b0, 1'b0, HAZ, 1'b0);
        id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b1;
        vec("lu_rt", 1'b0, 1'b0, HAZ, 1'b0);
        id_uses_rt = 1'b0;
        vec("rt_not_src", 1'b1, 1'b0, RUN, 1'b0);
        ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
        vec("r0_no_haz", 1'b1, 1'b0, RUN, 1'b0);
        ex_memread = 1'b0; ex_rt = 5'd9; id_rs = 5'd9;
        vec("no_load", 1'b1, 1'b0, RUN, 1'b0);

        ex_memread = 1'b1; ex_branch_taken = 1'b1;
        vec("lu_branch", 1'b1, 1'b1, REDIR, 1'b0);
        idle();
        ex_branch_taken = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) vec("mem_stall", 1'b0, 1'b0, HOLD, 1'b0);
        mem_ready = 1'b1;
        vec("redirect", 1'b1, 1'b1, REDIR, 1'b0);
        idle();
        vec("after_br", 1'b1, 1'b0, RUN, 1'b0);

        // Divide start, then HI/LO read held for the whole busy window.
        ex_mdu_start = 1'b1; ex_mdu_div = 1'b1;
        vec("div_start", 1'b1, 1'b0, RUN, 1'b0);
        ex_mdu_start = 1'b0; ex_mdu_div = 1'b0; id_hilo_use = 1'b1;
        for (int i = 0; i < 32; i++) begin
            vec("div_wait", ~MDU, 1'b0, MDU ? HAZ : RUN, MDU);
        end
        vec("div_done", 1'b1, 1'b0, RUN, 1'b0);
        idle();

        // Start ignored during memory stall.
        ex_mdu_start = 1'b1; mem_ready = 1'b0;
        vec("start_memstall", 1'b0, 1'b0, HOLD, 1'b0);
        idle();
        vec("no_load_busy", 1'b1, 1'b0, RUN, 1'b0);

        // Multiply: busy keeps counting down through memory stalls.
        ex_mdu_start = 1'b1;
        vec("mul_start", 1'b1, 1'b0, RUN, 1'b0);
        ex_mdu_start = 1'b0; mem_ready = 1'b0;
        vec("mul_ms1", 1'b0, 1'b0, HOLD, MDU);
        vec("mul_ms2", 1'b0, 1'b0, HOLD, MDU);
        mem_ready = 1'b1; id_hilo_use = 1'b1;
        vec("mul_w1", ~MDU, 1'b0, MDU ? HAZ : RUN, MDU);
        vec("mul_w2", ~MDU, 1'b0, MDU ? HAZ : RUN, MDU);
        vec("mul_done", 1'b1, 1'b0, RUN, 1'b0);
        idle();

        // Saturating counter: long load-use stall.
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        for (int i = 0; i < 17; i++) vec("sat", 1'b0, 1'b0, HAZ, 1'b0);
        idle();
        vec("sat_hold", 1'b1, 1'b0, RUN, 1'b0);

        // Reset in the middle of a multiply.
        ex_mdu_start = 1'b1;
        vec("mul2_start", 1'b1, 1'b0, RUN, 1'b0);
        ex_mdu_start = 1'b0;
        vec("mul2_busy", 1'b1, 1'b0, RUN, MDU);
        rst_n = 1'b0;
        exp_cnt = '0;
        #1;
        check_all("rst_mid", 1'b0, 1'b0, RST, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        id_hilo_use = 1'b1;
        vec("post_rst", 1'b1, 1'b0, RUN, 1'b0);
        idle();
        vec("post_rst2", 1'b1, 1'b0, RUN, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
